// File: rtl/battle_engine_if.sv
// battle_engine_if: control, damage and display signals between the game FSM and the combat engine
interface battle_engine_if #(parameter int HP_W = 8);
  logic            start;
  logic            boss;
  logic            key_valid;
  logic [7:0]      key_in;
  logic [HP_W-1:0] enemy_hit;
  logic            acc_force_en;
  logic [3:0]      acc_force;
  logic [HP_W-1:0] HP_player;
  logic [HP_W-1:0] HP_enemy;
  logic [2:0]      p_attack;
  logic [2:0]      e_attack;
  logic            player_turn;
  logic            win;
  logic            lose;
  modport master (
    output start, boss, key_valid, key_in, enemy_hit, acc_force_en, acc_force,
    input  HP_player, HP_enemy, p_attack, e_attack, player_turn, win, lose
  );
  modport slave (
    input  start, boss, key_valid, key_in, enemy_hit, acc_force_en, acc_force,
    output HP_player, HP_enemy, p_attack, e_attack, player_turn, win, lose
  );
endinterface

// File: rtl/battle_engine.sv
// battle_engine: turn-based combat with LFSR accuracy rolls, defend move and saturating HP
module battle_engine #(
  parameter int          HP_W            = 8,
  parameter int          PLAYER_HP       = 100,
  parameter int          ENEMY_HP_MIN    = 50,
  parameter int          ENEMY_RAND_BITS = 5,
  parameter int          BOSS_HP         = 150,
  parameter int          NUM_ATTACKS     = 4,
  parameter int          DMG_STEP        = 10,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input logic            clk_b,
  input logic            rst,
  battle_engine_if.slave bus
);
  typedef enum logic [2:0] {IDLE, INIT, PLAYER_WAIT, PLAYER_RES, ENEMY_RES, WIN, LOSE} state_t;
  state_t          state_q, state_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [HP_W-1:0] hp_player_q, hp_player_d, hp_enemy_q, hp_enemy_d;
  logic [2:0]      p_attack_q, p_attack_d, e_attack_q, e_attack_d, key_q, key_d;
  logic            defend_q, defend_d, boss_q, boss_d;
  logic            player_turn_q, player_turn_d, win_q, win_d, lose_q, lose_d;
  logic [3:0]      acc_p, acc_e;
  logic [HP_W-1:0] p_dmg, e_dmg, hp_e_sub, hp_p_sub;
  logic            p_hit, e_hit;
  function automatic logic [3:0] acc_map(input logic [3:0] r);
    return r < 4'd10 ? r : r - 4'd10;
  endfunction
  assign acc_p    = bus.acc_force_en ? bus.acc_force : acc_map(lfsr_q[3:0]);
  assign acc_e    = bus.acc_force_en ? bus.acc_force : acc_map(lfsr_q[7:4]);
  assign p_hit    = key_q != 3'd0 && acc_p >= {1'b0, key_q};
  assign e_hit    = acc_e >= 4'd3;
  assign p_dmg    = HP_W'(key_q) * HP_W'(DMG_STEP);
  assign e_dmg    = defend_q ? bus.enemy_hit >> 1 : bus.enemy_hit;
  assign hp_e_sub = hp_enemy_q > p_dmg ? hp_enemy_q - p_dmg : '0;
  assign hp_p_sub = hp_player_q > e_dmg ? hp_player_q - e_dmg : '0;
  always_comb begin
    state_d     = state_q;
    lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    hp_player_d = hp_player_q;
    hp_enemy_d  = hp_enemy_q;
    p_attack_d  = p_attack_q;
    e_attack_d  = e_attack_q;
    key_d       = key_q;
    defend_d    = defend_q;
    boss_d      = boss_q;
    case (state_q)
      IDLE, WIN, LOSE: begin
        state_d = bus.start ? INIT : state_q;
        boss_d  = bus.start ? bus.boss : boss_q;
      end
      INIT: begin
        hp_player_d = HP_W'(PLAYER_HP);
        hp_enemy_d  = boss_q ? HP_W'(BOSS_HP)
                             : HP_W'(ENEMY_HP_MIN) + HP_W'(lfsr_q[ENEMY_RAND_BITS-1:0]);
        p_attack_d  = '0;
        e_attack_d  = '0;
        defend_d    = 1'b0;
        state_d     = PLAYER_WAIT;
      end
      PLAYER_WAIT: begin
        if (bus.key_valid && bus.key_in <= 8'(NUM_ATTACKS)) begin
          key_d   = bus.key_in[2:0];
          state_d = PLAYER_RES;
        end
      end
      PLAYER_RES: begin
        defend_d   = key_q == 3'd0;
        hp_enemy_d = p_hit ? hp_e_sub : hp_enemy_q;
        p_attack_d = p_hit ? key_q : 3'd0;
        state_d    = (p_hit && hp_e_sub == '0) ? WIN : ENEMY_RES;
      end
      ENEMY_RES: begin
        hp_player_d = e_hit ? hp_p_sub : hp_player_q;
        e_attack_d  = !e_hit ? 3'd0 : defend_q ? 3'd2 : 3'd1;
        defend_d    = 1'b0;
        state_d     = (e_hit && hp_p_sub == '0) ? LOSE : PLAYER_WAIT;
      end
      default: state_d = IDLE;
    endcase
    player_turn_d = state_d == PLAYER_WAIT;
    win_d         = state_d == WIN;
    lose_d        = state_d == LOSE;
  end
  always_ff @(posedge clk_b or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      lfsr_q        <= LFSR_SEED;
      hp_player_q   <= HP_W'(PLAYER_HP);
      hp_enemy_q    <= '0;
      p_attack_q    <= '0;
      e_attack_q    <= '0;
      key_q         <= '0;
      defend_q      <= 1'b0;
      boss_q        <= 1'b0;
      player_turn_q <= 1'b0;
      win_q         <= 1'b0;
      lose_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      lfsr_q        <= lfsr_d;
      hp_player_q   <= hp_player_d;
      hp_enemy_q    <= hp_enemy_d;
      p_attack_q    <= p_attack_d;
      e_attack_q    <= e_attack_d;
      key_q         <= key_d;
      defend_q      <= defend_d;
      boss_q        <= boss_d;
      player_turn_q <= player_turn_d;
      win_q         <= win_d;
      lose_q        <= lose_d;
    end
  end
  assign bus.HP_player   = hp_player_q;
  assign bus.HP_enemy    = hp_enemy_q;
  assign bus.p_attack    = p_attack_q;
  assign bus.e_attack    = e_attack_q;
  assign bus.player_turn = player_turn_q;
  assign bus.win         = win_q;
  assign bus.lose        = lose_q;
endmodule

// File: tb/tb_battle_engine.sv
// tb_battle_engine: directed turn table plus hand-written win/lose/reset sequences
module tb_battle_engine;
  logic clk_b = 1'b0;
  logic rst   = 1'b1;
  int   tests = 0;
  int   fails = 0;
  logic [15:0] m_lfsr;
  logic [7:0]  exp_rand_hp;
  battle_engine_if #(.HP_W(8)) bus();
  battle_engine dut (.clk_b(clk_b), .rst(rst), .bus(bus));
  always #5 clk_b = ~clk_b;
  // Reference LFSR: seed held in reset, one left shift per clock afterwards.
  always @(posedge clk_b or posedge rst)
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  typedef struct {
    logic [7:0] key;
    logic [3:0] acc;
    logic [7:0] ehit;
    logic [7:0] he;
    logic [7:0] hp;
    logic [2:0] pa;
    logic [2:0] ea;
  } vec_t;
  vec_t v[9];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic start_battle(input logic b, input logic with_key);
    bus.start = 1'b1;
    bus.boss = b;
    bus.key_valid = with_key;
    bus.key_in = 8'd1;
    @(negedge clk_b);
    bus.start = 1'b0;
    bus.key_valid = 1'b0;
    exp_rand_hp = 8'd50 + {3'd0, m_lfsr[4:0]};
    @(negedge clk_b);
  endtask
  task automatic turn(input logic [7:0] k, input logic [3:0] a, input logic [7:0] h);
    bus.key_valid = 1'b1;
    bus.key_in = k;
    bus.acc_force = a;
    bus.enemy_hit = h;
    @(negedge clk_b);
    bus.key_valid = 1'b0;
    @(negedge clk_b);
    @(negedge clk_b);
  endtask
  initial begin
    v[0] = '{8'd4, 4'd9, 8'd20, 8'd110, 8'd80, 3'd4, 3'd1};
    v[1] = '{8'd3, 4'd2, 8'd20, 8'd110, 8'd80, 3'd0, 3'd0};
    v[2] = '{8'd0, 4'd9, 8'd21, 8'd110, 8'd70, 3'd0, 3'd2};
    v[3] = '{8'd1, 4'd9, 8'd21, 8'd100, 8'd49, 3'd1, 3'd1};
    v[4] = '{8'd2, 4'd3, 8'd5,  8'd80,  8'd44, 3'd2, 3'd1};
    v[5] = '{8'd3, 4'd3, 8'd5,  8'd50,  8'd39, 3'd3, 3'd1};
    v[6] = '{8'd4, 4'd3, 8'd0,  8'd50,  8'd39, 3'd0, 3'd1};
    v[7] = '{8'd0, 4'd0, 8'd30, 8'd50,  8'd39, 3'd0, 3'd0};
    v[8] = '{8'd2, 4'd9, 8'd1,  8'd30,  8'd38, 3'd2, 3'd1};
    bus.start = 1'b0;
    bus.boss = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_in = 8'd0;
    bus.enemy_hit = 8'd0;
    bus.acc_force_en = 1'b1;
    bus.acc_force = 4'd9;
    repeat (2) @(negedge clk_b);
    rst = 1'b0;
    @(negedge clk_b);
    chk("rst_hp_player", bus.HP_player, 100);
    chk("rst_hp_enemy", bus.HP_enemy, 0);
    chk("rst_p_attack", bus.p_attack, 0);
    chk("rst_e_attack", bus.e_attack, 0);
    chk("rst_flags", {bus.player_turn, bus.win, bus.lose}, 0);
    start_battle(1'b0, 1'b0);
    chk("norm_hp_player", bus.HP_player, 100);
    chk("norm_hp_enemy", bus.HP_enemy, exp_rand_hp);
    chk("norm_hp_range", bus.HP_enemy >= 50 && bus.HP_enemy <= 81, 1);
    chk("norm_turn", bus.player_turn, 1);
    rst = 1'b1;
    @(negedge clk_b);
    rst = 1'b0;
    @(negedge clk_b);
    start_battle(1'b1, 1'b0);
    chk("boss_hp_enemy", bus.HP_enemy, 150);
    for (int i = 0; i < 9; i++) begin
      turn(v[i].key, v[i].acc, v[i].ehit);
      chk($sformatf("v%0d_hp_enemy", i), bus.HP_enemy, v[i].he);
      chk($sformatf("v%0d_hp_player", i), bus.HP_player, v[i].hp);
      chk($sformatf("v%0d_p_attack", i), bus.p_attack, v[i].pa);
      chk($sformatf("v%0d_e_attack", i), bus.e_attack, v[i].ea);
      chk($sformatf("v%0d_turn", i), bus.player_turn, 1);
    end
    turn(8'd9, 4'd9, 8'd50);
    chk("badkey_turn", bus.player_turn, 1);
    chk("badkey_hp_enemy", bus.HP_enemy, 30);
    chk("badkey_hp_player", bus.HP_player, 38);
    bus.key_valid = 1'b1;
    bus.key_in = 8'd4;
    bus.acc_force = 4'd9;
    @(negedge clk_b);
    bus.key_valid = 1'b0;
    @(negedge clk_b);
    chk("win_hp_enemy", bus.HP_enemy, 0);
    chk("win_p_attack", bus.p_attack, 4);
    chk("win_flag", {bus.win, bus.lose, bus.player_turn}, 3'b100);
    repeat (3) @(negedge clk_b);
    chk("win_hold_flag", bus.win, 1);
    chk("win_hold_hp_player", bus.HP_player, 38);
    chk("win_hold_e_attack", bus.e_attack, 1);
    start_battle(1'b0, 1'b1);
    chk("restart_turn", {bus.win, bus.player_turn}, 2'b01);
    chk("restart_hp_player", bus.HP_player, 100);
    chk("restart_hp_enemy", bus.HP_enemy, exp_rand_hp);
    chk("restart_attacks", {bus.p_attack, bus.e_attack}, 0);
    @(negedge clk_b);
    chk("restart_key_dropped", {bus.player_turn, bus.HP_enemy}, {1'b1, exp_rand_hp});
    rst = 1'b1;
    @(negedge clk_b);
    rst = 1'b0;
    @(negedge clk_b);
    start_battle(1'b1, 1'b0);
    turn(8'd0, 4'd9, 8'd180);
    chk("lose_defend_hp", bus.HP_player, 10);
    chk("lose_defend_ea", bus.e_attack, 2);
    turn(8'd1, 4'd9, 8'd50);
    chk("lose_hp_player", bus.HP_player, 0);
    chk("lose_hp_enemy", bus.HP_enemy, 140);
    chk("lose_flag", {bus.win, bus.lose, bus.player_turn}, 3'b010);
    start_battle(1'b1, 1'b0);
    bus.key_valid = 1'b1;
    bus.key_in = 8'd1;
    bus.enemy_hit = 8'd20;
    @(negedge clk_b);
    bus.key_valid = 1'b0;
    @(negedge clk_b);
    chk("lat_hp_enemy", bus.HP_enemy, 140);
    chk("lat_hp_player", bus.HP_player, 100);
    chk("lat_turn", bus.player_turn, 0);
    rst = 1'b1;
    #1;
    chk("arst_hp_enemy", bus.HP_enemy, 0);
    chk("arst_hp_player", bus.HP_player, 100);
    chk("arst_attacks", {bus.p_attack, bus.e_attack}, 0);
    chk("arst_flags", {bus.player_turn, bus.win, bus.lose}, 0);
    @(negedge clk_b);
    rst = 1'b0;
    repeat (3) @(negedge clk_b);
    chk("arst_idle_hp_player", bus.HP_player, 100);
    chk("arst_idle_flags", {bus.player_turn, bus.HP_enemy}, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
